// File: rtl/stream_mux_pkg.sv
// Shared types and limits for the stream_mux_rr block.
package stream_mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_t;

  localparam int N_MAX     = 32;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted req at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant_idx,
  output logic            grant_any
);

  localparam logic [SELW:0] N_EXT = (SELW + 1)'(N);

  logic [SELW:0] cand;

  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (SELW + 1)'(i);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (req[cand[SELW-1:0]]) begin
        grant_idx = cand[SELW-1:0];
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with round-robin or forced select.
// Optional packet lock on i_last is enabled by defining STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr #(
  parameter  int N     = 8,
  parameter  int WIDTH = 32,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_mode,
  input  logic [SELW-1:0]      i_sel,
  input  logic [N*WIDTH-1:0]   i_data,
  input  logic [N-1:0]         i_valid,
  input  logic [N-1:0]         i_last,
  output logic [N-1:0]         o_ready,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_valid,
  output logic [SELW-1:0]      o_sel,
  input  logic                 i_ready
);

  import stream_mux_pkg::*;

  localparam logic [SELW:0] N_EXT = (SELW + 1)'(N);

  // Handshake: a beat moves when valid && ready; o_ready never depends on i_valid
  // of the same channel except through the grant, and is forced low during rst.
  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_data_q,  o_data_d;
  logic [SELW-1:0]  o_sel_q,   o_sel_d;
  logic [SELW-1:0]  p_q,       p_d;

  logic             load, xfer, grant_any, rr_any;
  logic [SELW-1:0]  grant_idx, rr_idx, next_idx;
  mode_t            mode;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock_q,    lock_d;
  logic [SELW-1:0]  lock_ch_q, lock_ch_d;
`else
  logic             unused_last;
  assign unused_last = ^i_last;
`endif

  assign mode = mode_t'(i_mode);
  assign load = !o_valid_q || i_ready;

  rr_arbiter #(.N(N)) u_arb (
    .req       (i_valid),
    .ptr       (p_q),
    .grant_idx (rr_idx),
    .grant_any (rr_any)
  );

  always_comb begin
    grant_idx = rr_idx;
    grant_any = rr_any;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      grant_idx = lock_ch_q;
      grant_any = i_valid[lock_ch_q];
    end else
`endif
    if (mode == MODE_FIXED) begin
      grant_idx = i_sel;
      grant_any = ({1'b0, i_sel} < N_EXT) && i_valid[i_sel];
    end
  end

  assign xfer     = load && grant_any && !rst;
  assign o_ready  = xfer ? (N'(1'b1) << grant_idx) : '0;
  assign next_idx = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_sel_d   = o_sel_q;
    p_d       = p_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
`endif
    if (load) begin
      o_valid_d = xfer;
    end
    if (xfer) begin
      o_data_d = i_data[int'(grant_idx)*WIDTH +: WIDTH];
      o_sel_d  = grant_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
      // A non-last beat holds the grant; the pointer only moves once the packet ends.
      lock_d    = !i_last[grant_idx];
      lock_ch_d = grant_idx;
      if (i_last[grant_idx] && (lock_q || mode == MODE_RR)) begin
        p_d = next_idx;
      end
`else
      if (mode == MODE_RR) begin
        p_d = next_idx;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_sel_q   <= '0;
      p_q       <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
`endif
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_sel_q   <= o_sel_d;
      p_q       <= p_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
`endif
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_sel   = o_sel_q;

endmodule
